vga_timing_gen: RTL and testbench

Raster timing source for the pattern generators. Produces pixel coordinates, the active-video flag, and the sync pulses for a 640x480 VGA frame. Also produces a single-cycle `next_frame` strobe that pattern blocks use to advance their animation state. Sits between the pixel clock and every pattern generator or RGB mux; it drives the `x`, `y`, `active` and `next_frame` inputs those blocks consume.

---
 rtl/vga_timing_gen.sv | 88 ++++++++
 tb/tb_vga_timing_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480 VGA raster timing: pixel position, active-video flag, sync pulses and a frame strobe.
// Define VGA_TIMING_PIXEL_DIV2_EN to advance one pixel every second clk.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   output logic       hsync,
   output logic       vsync,
   output logic       active,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       next_frame
);

   localparam int unsigned W        = 10;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ACTIVE + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   // Counters are 10 bits wide; larger rasters cannot be represented.
   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   logic         tick_c;
   logic [W-1:0] h_nxt_c;
   logic [W-1:0] v_nxt_c;

`ifdef VGA_TIMING_PIXEL_DIV2_EN
   logic phase;

   // Pixel tick on every second clk; first tick lands on the 2nd edge after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) phase <= 1'b0;
      else     phase <= ~phase;
   end

   assign tick_c = phase;
`else
   assign tick_c = 1'b1;
`endif

   // Next raster position; x/y are the position registers themselves.
   always_comb begin
      h_nxt_c = x;
      v_nxt_c = y;
      if (tick_c) begin
         if (x == W'(H_TOTAL - 1)) begin
            h_nxt_c = '0;
            v_nxt_c = (y == W'(V_TOTAL - 1)) ? '0 : y + W'(1);
         end else begin
            h_nxt_c = x + W'(1);
         end
      end
   end

   // All outputs decode the next position so they share the position's edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x          <= W'(H_TOTAL - 1);
         y          <= W'(V_TOTAL - 1);
         active     <= 1'b0;
         hsync      <= ~SYNC_POL;
         vsync      <= ~SYNC_POL;
         next_frame <= 1'b0;
      end else begin
         x          <= h_nxt_c;
         y          <= v_nxt_c;
         active     <= (h_nxt_c < W'(H_ACTIVE)) && (v_nxt_c < W'(V_ACTIVE));
         hsync      <= ((h_nxt_c >= W'(HS_START)) && (h_nxt_c < W'(HS_END))) ? SYNC_POL : ~SYNC_POL;
         vsync      <= ((v_nxt_c >= W'(VS_START)) && (v_nxt_c < W'(VS_END))) ? SYNC_POL : ~SYNC_POL;
         next_frame <= tick_c && (h_nxt_c == '0) && (v_nxt_c == W'(V_ACTIVE));
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for reset/line checks, reduced raster for frame checks.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIXEL_DIV2_EN
   localparam int DIV = 2;
`else
   localparam int DIV = 1;
`endif

   // Reduced raster: 60 x 37 positions, sync active-high.
   localparam int S_HA = 40, S_HFP = 4, S_HS = 8, S_HBP = 8;
   localparam int S_VA = 30, S_VFP = 2, S_VS = 2, S_VBP = 3;
   localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
   localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;
   localparam int S_F  = S_HT * S_VT;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       active;
      logic       hsync;
      logic       vsync;
      logic       nf;
   } obs_t;

   logic       clk = 1'b0;
   logic       clk_run = 1'b0;
   logic       rst_b, rst_s;
   logic       hsync_b, vsync_b, active_b, nf_b;
   logic       hsync_s, vsync_s, active_s, nf_s;
   logic [9:0] x_b, y_b, x_s, y_s;
   obs_t       obs_b, obs_s;

   int vectors = 0;
   int miscompares = 0;
   int kb = 0, ks = 0, cyc = 0;
   int act_l0 = 0, hs_l0 = 0;
   int act_cnt = 0, vs_cnt = 0, nf_cnt = 0, last_nf = -1;
   bit win_on = 1'b0;
   obs_t last_s;
   obs_t sb_b[$];
   obs_t sb_s[$];

   always #5 if (clk_run) clk = ~clk;

   vga_timing_gen dut_b (
      .clk(clk), .rst(rst_b), .hsync(hsync_b), .vsync(vsync_b), .active(active_b),
      .x(x_b), .y(y_b), .next_frame(nf_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
      .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
      .SYNC_POL(1'b1)
   ) dut_s (
      .clk(clk), .rst(rst_s), .hsync(hsync_s), .vsync(vsync_s), .active(active_s),
      .x(x_s), .y(y_s), .next_frame(nf_s)
   );

   assign obs_b = {x_b, y_b, active_b, hsync_b, vsync_b, nf_b};
   assign obs_s = {x_s, y_s, active_s, hsync_s, vsync_s, nf_s};

   // Expected outputs after k clk edges since reset release, from the pixel index alone.
   function automatic obs_t model(input int k, input int ha, input int hfp, input int hs, input int hbp,
                                  input int va, input int vfp, input int vs, input int vbp, input logic pol);
      obs_t o;
      int ht, vt, t, p, xx, yy;
      ht = ha + hfp + hs + hbp;
      vt = va + vfp + vs + vbp;
      t  = k / DIV;
      if (t == 0) begin
         o.x = 10'(ht - 1); o.y = 10'(vt - 1);
         o.active = 1'b0; o.hsync = ~pol; o.vsync = ~pol; o.nf = 1'b0;
      end else begin
         p  = (t - 1) % (ht * vt);
         xx = p % ht;
         yy = p / ht;
         o.x      = 10'(xx);
         o.y      = 10'(yy);
         o.active = (xx < ha) && (yy < va);
         o.hsync  = (xx >= ha + hfp && xx < ha + hfp + hs) ? pol : ~pol;
         o.vsync  = (yy >= va + vfp && yy < va + vfp + vs) ? pol : ~pol;
         o.nf     = (k % DIV == 0) && (xx == 0) && (yy == va);
      end
      return o;
   endfunction

   function automatic obs_t exp_b(input int k);
      return model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
   endfunction

   function automatic obs_t exp_s(input int k);
      return model(k, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1);
   endfunction

   task automatic check(input string tag, input obs_t got, input obs_t exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One clk: push expectations for the coming edge, then pop and compare just after it.
   task automatic step();
      int nb, ns;
      obs_t eb, es;
      nb = rst_b ? 0 : kb + 1;
      ns = rst_s ? 0 : ks + 1;
      sb_b.push_back(exp_b(nb));
      sb_s.push_back(exp_s(ns));
      @(posedge clk);
      kb = nb;
      ks = ns;
      cyc++;
      #1;
      eb = sb_b.pop_front();
      es = sb_s.pop_front();
      last_s = es;
      check("big_pos", obs_b, eb);
      check("small_pos", obs_s, es);
      if (y_b == 10'd0 && active_b) act_l0++;
      if (y_b == 10'd0 && !hsync_b) hs_l0++;
      if (win_on) begin
         if (vsync_s) vs_cnt++;
         if (active_s) act_cnt++;
         if (nf_s) begin
            nf_cnt++;
            if (last_nf >= 0) check_int("nf_spacing", cyc - last_nf, S_F * DIV);
            last_nf = cyc;
         end
      end
   endtask

   initial begin
      int n;
      bit found;
      rst_b = 1'b1;
      rst_s = 1'b1;
      #2;
      check("rst_noclk_big", obs_b, exp_b(0));
      check("rst_noclk_small", obs_s, exp_s(0));
      clk_run = 1'b1;
      repeat (2) step();

      rst_b = 1'b0;
      rst_s = 1'b0;
      win_on = 1'b1;
      repeat (3 * S_F * DIV) step();
      win_on = 1'b0;

      check_int("line0_active", act_l0, 640 * DIV);
      check_int("line0_hsync", hs_l0, 96 * DIV);
      check_int("frame_active", act_cnt, 3 * S_HA * S_VA * DIV);
      check_int("frame_vsync", vs_cnt, 3 * S_VS * S_HT * DIV);
      check_int("nf_count", nf_cnt, 3);

      // Mid-frame asynchronous reset on the reduced raster.
      for (int i = 0; i < 3000 * DIV; i++) begin
         if (last_s.x == 10'd30 && last_s.y == 10'd20) break;
         step();
      end
      check_int("mid_pos", {22'd0, x_s}, 30);
      #1;
      rst_s = 1'b1;
      #1;
      ks = 0;
      check("async_rst", obs_s, exp_s(0));
      repeat (3) step();
      rst_s = 1'b0;

      n = 0;
      found = 1'b0;
      for (int i = 0; i < 2 * S_F * DIV; i++) begin
         step();
         n++;
         if (nf_s) begin
            found = 1'b1;
            break;
         end
      end
      check_int("strobe_after_rst", found ? n : -1, (S_VA * S_HT + 1) * DIV);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
